// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file geometry for the scoreboard, register file and pipeline registers.
package reg_scoreboard_pkg;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int CNT_W    = 2;
   localparam int PERF_W   = 16;
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_sb_counter.sv
// Per-register pending-write counter: inc on issue, dec on retire, holds when both.
module reg_sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             underflow_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Increment never wraps: the top blocks issue while the count is full.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) underflow_o = 1'b1;
         else             cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// RAW-hazard scoreboard for decode: per-register pending-write counts, stall generation,
// sticky retire-underflow flag and a saturating stall-cycle counter.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   src1_addr,
   input  logic                src1_used,
   input  logic [ADDR_W-1:0]   src2_addr,
   input  logic                src2_used,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic                dst_used,
   input  logic                reg_wr,
   input  logic [ADDR_W-1:0]   reg_wr_addr,
   output logic                stall_flag,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                underflow_err,
   output logic [PERF_W-1:0]   stall_cycles
);
   logic [NUM_REGS-1:1]            hit, fire, uf_vec;
   logic [NUM_REGS-1:1][CNT_W-1:0] cnt;
   logic [NUM_REGS-1:0][CNT_W-1:0] pend;
   logic                           src1_haz, src2_haz, dst_full, issue_fire;
   logic                           underflow_q, underflow_d;
   logic [PERF_W-1:0]              stall_q, stall_d;

   assign pend[ZERO_REG]      = '0;
   assign busy_mask[ZERO_REG] = 1'b0;

   // A retire against an empty counter is an error, not a pending write, so pend floors at 0.
   for (genvar g = ZERO_REG + 1; g < NUM_REGS; g++) begin : g_reg
      assign hit[g]       = reg_wr && (reg_wr_addr == ADDR_W'(g));
      assign fire[g]      = issue_fire && (dst_addr == ADDR_W'(g));
      assign pend[g]      = (cnt[g] == '0) ? '0 : cnt[g] - CNT_W'(hit[g]);
      assign busy_mask[g] = (cnt[g] != '0);

      reg_sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk        (clk),
         .reset      (reset),
         .inc_i      (fire[g]),
         .dec_i      (hit[g]),
         .cnt_o      (cnt[g]),
         .underflow_o(uf_vec[g])
      );
   end

   assign src1_haz   = issue_valid && src1_used && (src1_addr != '0) && (pend[src1_addr] != '0);
   assign src2_haz   = issue_valid && src2_used && (src2_addr != '0) && (pend[src2_addr] != '0);
   assign dst_full   = issue_valid && dst_used && (dst_addr != '0) && (pend[dst_addr] == '1);
   assign stall_flag = src1_haz | src2_haz | dst_full;
   assign issue_fire = issue_valid && !stall_flag && dst_used && (dst_addr != '0);

   always_comb begin
      stall_d     = stall_q;
      underflow_d = underflow_q | (|uf_vec);
      if (stall_flag && (stall_q != '1)) stall_d = stall_q + PERF_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         underflow_q <= underflow_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign underflow_err = underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed vector table, reset/saturation sequences, random traffic vs model.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   typedef struct packed {
      logic             iv;
      logic [ADDR_W-1:0] s1;
      logic             s1u;
      logic [ADDR_W-1:0] s2;
      logic             s2u;
      logic [ADDR_W-1:0] d;
      logic             du;
      logic             wr;
      logic [ADDR_W-1:0] wa;
   } in_t;

   typedef struct {
      in_t         in;
      logic        stall;
      logic [31:0] busy;
      logic        uf;
   } vec_t;

   logic                clk, reset;
   logic                issue_valid, src1_used, src2_used, dst_used, reg_wr;
   logic [ADDR_W-1:0]   src1_addr, src2_addr, dst_addr, reg_wr_addr;
   logic                stall_flag, underflow_err;
   logic [NUM_REGS-1:0] busy_mask;
   logic [PERF_W-1:0]   stall_cycles;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: plain integer counts per register.
   int m_cnt [NUM_REGS];
   bit m_uf;
   int m_sc;

   vec_t tbl[$];

   reg_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .src1_addr    (src1_addr),
      .src1_used    (src1_used),
      .src2_addr    (src2_addr),
      .src2_used    (src2_used),
      .dst_addr     (dst_addr),
      .dst_used     (dst_used),
      .reg_wr       (reg_wr),
      .reg_wr_addr  (reg_wr_addr),
      .stall_flag   (stall_flag),
      .busy_mask    (busy_mask),
      .underflow_err(underflow_err),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mk(bit iv, int s1, bit s1u, int s2, bit s2u, int d, bit du,
                              bit wr, int wa);
      in_t v;
      v.iv = iv;  v.s1 = ADDR_W'(s1); v.s1u = s1u; v.s2 = ADDR_W'(s2); v.s2u = s2u;
      v.d  = ADDR_W'(d); v.du = du; v.wr = wr; v.wa = ADDR_W'(wa);
      return v;
   endfunction

   function automatic in_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic void addv(in_t v, bit st, logic [31:0] bm, bit uf);
      vec_t e;
      e.in = v; e.stall = st; e.busy = bm; e.uf = uf;
      tbl.push_back(e);
   endfunction

   function automatic void m_reset();
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_uf = 0;
      m_sc = 0;
   endfunction

   // Outstanding writes to r once this cycle's writeback has landed.
   function automatic int m_pend(int r, in_t v);
      int p;
      if (r == 0) return 0;
      p = m_cnt[r] - ((v.wr && int'(v.wa) == r) ? 1 : 0);
      return (p < 0) ? 0 : p;
   endfunction

   function automatic bit m_stall(in_t v);
      bit h1, h2, full;
      h1   = v.iv && v.s1u && v.s1 != 0 && m_pend(int'(v.s1), v) != 0;
      h2   = v.iv && v.s2u && v.s2 != 0 && m_pend(int'(v.s2), v) != 0;
      full = v.iv && v.du && v.d != 0 && m_pend(int'(v.d), v) == (1 << CNT_W) - 1;
      return h1 || h2 || full;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < NUM_REGS; r++) b[r] = (m_cnt[r] != 0);
      return b;
   endfunction

   function automatic void m_update(in_t v, bit st);
      bit fire, h, f;
      fire = v.iv && !st && v.du && v.d != 0;
      for (int r = 1; r < NUM_REGS; r++) begin
         h = v.wr && int'(v.wa) == r;
         f = fire && int'(v.d) == r;
         if (f && !h) m_cnt[r]++;
         else if (h && !f) begin
            if (m_cnt[r] == 0) m_uf = 1;
            else m_cnt[r]--;
         end
      end
      if (st && m_sc < (1 << PERF_W) - 1) m_sc++;
   endfunction

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(in_t v);
      issue_valid = v.iv;  src1_addr = v.s1; src1_used = v.s1u;
      src2_addr   = v.s2;  src2_used = v.s2u;
      dst_addr    = v.d;   dst_used  = v.du;
      reg_wr      = v.wr;  reg_wr_addr = v.wa;
   endtask

   // Drive on the negedge, sample 1 ns later, then advance the model at the posedge.
   task automatic step(in_t v, bit chk, output logic st, output logic [31:0] bm,
                       output logic uf);
      bit exp_st;
      @(negedge clk);
      drive(v);
      #1;
      st = stall_flag; bm = busy_mask; uf = underflow_err;
      exp_st = m_stall(v);
      if (chk) begin
         check("stall_flag",    64'(stall_flag),    64'(exp_st));
         check("busy_mask",     64'(busy_mask),     64'(m_busy()));
         check("underflow_err", 64'(underflow_err), 64'(m_uf));
         check("stall_cycles",  64'(stall_cycles),  64'(m_sc));
      end
      @(posedge clk);
      m_update(v, exp_st);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      m_reset();
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      logic        st, uf;
      logic [31:0] bm;
      in_t         v;

      // RAW on r5 via src1 then src2, same-cycle retire clears the hazard
      addv(mk(1,0,0,0,0,5,1,0,0), 0, 32'h0,   0);
      addv(mk(1,5,1,0,0,0,0,0,0), 1, 32'h20,  0);
      addv(mk(1,0,0,5,1,0,0,0,0), 1, 32'h20,  0);
      addv(mk(1,5,1,0,0,0,0,1,5), 0, 32'h20,  0);
      addv(idle(),                0, 32'h0,   0);
      // r7 fills to 3; 4th issue stalls; issue+retire keeps it full
      addv(mk(1,0,0,0,0,7,1,0,0), 0, 32'h0,   0);
      addv(mk(1,0,0,0,0,7,1,0,0), 0, 32'h80,  0);
      addv(mk(1,0,0,0,0,7,1,0,0), 0, 32'h80,  0);
      addv(mk(1,0,0,0,0,7,1,0,0), 1, 32'h80,  0);
      addv(mk(1,0,0,0,0,7,1,1,7), 0, 32'h80,  0);
      addv(mk(1,0,0,0,0,7,1,0,0), 1, 32'h80,  0);
      addv(mk(0,0,0,0,0,0,0,1,7), 0, 32'h80,  0);
      addv(mk(0,0,0,0,0,0,0,1,7), 0, 32'h80,  0);
      addv(mk(0,0,0,0,0,0,0,1,7), 0, 32'h80,  0);
      addv(idle(),                0, 32'h0,   0);
      // r9: simultaneous issue and retire leaves count at 1
      addv(mk(1,0,0,0,0,9,1,0,0), 0, 32'h0,   0);
      addv(mk(1,0,0,0,0,9,1,1,9), 0, 32'h200, 0);
      addv(idle(),                0, 32'h200, 0);
      addv(mk(0,0,0,0,0,0,0,1,9), 0, 32'h200, 0);
      addv(idle(),                0, 32'h0,   0);
      // zero register is inert
      addv(mk(1,0,1,0,1,0,1,1,0), 0, 32'h0,   0);
      addv(idle(),                0, 32'h0,   0);
      // retire of an empty r12 sets the sticky error
      addv(mk(0,0,0,0,0,0,0,1,12),0, 32'h0,   0);
      addv(idle(),                0, 32'h0,   1);
      addv(idle(),                0, 32'h0,   1);

      drive(idle());
      reset = 1'b0;
      m_reset();
      #12 reset = 1'b1;
      step(idle(), 1, st, bm, uf);

      foreach (tbl[i]) begin
         step(tbl[i].in, 1, st, bm, uf);
         check($sformatf("tbl%0d.stall", i), 64'(st), 64'(tbl[i].stall));
         check($sformatf("tbl%0d.busy", i),  64'(bm), 64'(tbl[i].busy));
         check($sformatf("tbl%0d.uf", i),    64'(uf), 64'(tbl[i].uf));
      end

      // Async reset mid-run: pending r4, a stalled reader, and no clock edge taken
      step(mk(1,0,0,0,0,4,1,0,0), 1, st, bm, uf);
      step(mk(1,0,0,0,0,4,1,0,0), 1, st, bm, uf);
      @(negedge clk);
      drive(mk(1,4,1,0,0,0,0,0,0));
      #1 check("pre_reset.stall", 64'(stall_flag), 64'(1));
      #2 reset = 1'b0;
      #1;
      check("async_reset.busy",  64'(busy_mask),     64'(0));
      check("async_reset.stall", 64'(stall_flag),    64'(0));
      check("async_reset.perf",  64'(stall_cycles),  64'(0));
      check("async_reset.uf",    64'(underflow_err), 64'(0));
      m_reset();
      @(posedge clk);
      #2 reset = 1'b1;

      // Random traffic on a small register window to force frequent hazards
      for (int n = 0; n < 2000; n++) begin
         v = mk($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(1, 0),
                $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                $urandom_range(1, 0), $urandom_range(9, 0) < 4, $urandom_range(7, 0));
         step(v, 1, st, bm, uf);
      end

      // Perf counter saturation
      pulse_reset();
      step(mk(1,0,0,0,0,3,1,0,0), 1, st, bm, uf);
      for (int n = 0; n < 70000; n++) step(mk(1,3,1,0,0,0,0,0,0), 0, st, bm, uf);
      step(mk(1,3,1,0,0,0,0,0,0), 1, st, bm, uf);
      #1 check("perf_saturated", 64'(stall_cycles), 64'(16'hFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
